// File: rtl/slice_serial_adder.sv
// slice_serial_adder: adds two WIDTH-bit operands three bits per cycle behind a valid/ready handshake
module slice_serial_adder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);
  localparam int SLICE = 3;
  localparam int N = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] ra, rb, res;
  logic carry, accept, last;
  logic [CW-1:0] cnt;
  logic [SLICE:0] r;
  function automatic logic [SLICE:0] add_slice(input logic [SLICE-1:0] x, y, input logic ci);
    logic [SLICE:0] c;
    logic [SLICE-1:0] s;
    c[0] = ci;
    for (int k = 0; k < SLICE; k++) begin
      s[k] = x[k] ^ y[k] ^ c[k];
      c[k+1] = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
    end
    return {c[SLICE], s};
  endfunction
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    accept = in_valid && in_ready;
    last = cnt == CW'(N - 1);
    r = add_slice(ra[SLICE-1:0], rb[SLICE-1:0], carry);
    out_valid = state == DONE;
    sum = out_valid ? {carry, res} : '0;
    state_d = accept ? RUN
            : (state == RUN && last) ? DONE
            : (state == DONE && out_ready) ? IDLE
            : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        ra <= a;
        rb <= b;
        carry <= cin;
        cnt <= '0;
      end else if (state == RUN) begin
        res[SLICE*int'(cnt) +: SLICE] <= r[SLICE-1:0];
        carry <= r[SLICE];
        ra <= ra >> SLICE;
        rb <= rb >> SLICE;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/slice_serial_adder.md
SLICE_SERIAL_ADDER -- requirements
Module: slice_serial_adder

Interface
REQ-001 Parameter WIDTH, default 12, operand width in bits; SHALL be a positive multiple of 3.
REQ-002 Parameter SLICE, fixed at 3, bits added per cycle by the internal 3-bit ripple slice; not user-overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on a, b, cin is valid.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 cin  input  1  carry-in to bit 0.
REQ-010 out_valid  output  1  sum is valid.
REQ-011 out_ready  input  1  downstream accepts sum this cycle.
REQ-012 sum  output  WIDTH+1  {carry-out, WIDTH-bit sum}.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, capture a, b, cin into shift registers, clear slice counter, go to RUN.
REQ-015 RUN: each cycle add the low 3 bits of the captured a and b plus the registered carry; register the 3 sum bits into the result register at slice position = counter; register carry-out as next carry; shift operand registers right by 3; increment counter.
REQ-016 Per-slice arithmetic SHALL be s[k]=a[k]^b[k]^c[k], c[k+1]=(a[k]&b[k])|(c[k]&(a[k]^b[k])) for k=0..2, with c[0]=registered carry.
REQ-017 RUN SHALL last exactly WIDTH/3 cycles; on the cycle the last slice is processed, go to DONE.
REQ-018 DONE: out_valid=1, sum={final carry, result}; sum and out_valid SHALL hold stable until out_ready=1.
REQ-019 DONE with out_ready=1: in_ready=1 in the same cycle; if in_valid=1, capture new operands and go to RUN, else go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and in DONE when out_ready=0; in_valid in those cycles SHALL be ignored and operands not captured.
REQ-021 Latency: operand accept at cycle T -> out_valid first high at cycle T+WIDTH/3+1.
REQ-022 WIDTH=3: RUN lasts exactly one cycle.
REQ-023 Inputs a, b, cin SHALL be sampled only at accept; changes afterward SHALL not affect the in-flight result.
REQ-024 Result SHALL equal (a+b+cin) mod 2^(WIDTH+1), with bit WIDTH the carry-out, for all operand values including all-ones.
REQ-025 Counter SHALL be ceil(log2(WIDTH/3+1)) bits wide and SHALL not wrap during RUN.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, in_ready=1 on the following cycle, out_valid=0, sum=0, carry=0, counter=0, regardless of current state.
REQ-027 Reset during RUN or DONE SHALL abort the operation; no out_valid for the aborted operand set.
REQ-028 in_valid asserted in the same cycle as rst SHALL not be accepted.

Verification
REQ-029 WIDTH=12, a=0xFFF, b=0x001, cin=0 accepted at T -> out_valid at T+5, sum=0x1000.
REQ-030 WIDTH=12, a=0x0A5, b=0x15A, cin=1 -> sum=0x0200; a and b changed to 0 during RUN -> sum unchanged.
REQ-031 Backpressure: out_ready=0 for 3 cycles in DONE -> sum, out_valid stable, in_ready=0; out_ready=1 with in_valid=1 (a=1,b=2,cin=0) -> back-to-back accept, next sum=0x0003 at accept+5.
REQ-032 rst=1 on second RUN cycle -> IDLE next cycle, out_valid never asserts; new operand a=b=0x800, cin=0 -> sum=0x1000.
REQ-033 WIDTH=3, a=7, b=7, cin=1 -> out_valid at accept+2, sum=0xF.
REQ-034 Random regression, 10k operand sets, random out_ready/in_valid: every sum matches a+b+cin, no lost or duplicated results.
